// File: rtl/sd_dat_writer_pkg.sv
// Shared types and constants for the SD DAT-bus block writer.
package sd_dat_writer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_CRC,
    ST_END,
    ST_TURN,
    ST_STATUS_WAIT,
    ST_STATUS,
    ST_BUSY
  } state_t;

  // CRC status tokens returned by the card on DAT0
  localparam logic [2:0] STATUS_ACCEPTED  = 3'b010;
  localparam logic [2:0] STATUS_CRC_ERR   = 3'b101;
  localparam logic [2:0] STATUS_WRITE_ERR = 3'b110;

  // x^16 + x^12 + x^5 + 1, leading term implied
  localparam logic [15:0] CRC16_POLY = 16'h1021;

endpackage

// File: rtl/sd_dat_writer_crc16_lane.sv
// Serial CRC16 for one DAT lane: accumulates data bits, then shifts the
// remainder out MSB first on dout.
module sd_crc16_lane
  import sd_dat_writer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic shift,
  input  logic din,
  output logic dout
);

  logic [15:0] crc;
  logic        fb;

  assign fb   = din ^ crc[15];
  assign dout = crc[15];

  // accumulate while data is driven, shift out the remainder afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        crc <= '0;
    else if (clear) crc <= '0;
    else if (en)    crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    else if (shift) crc <= {crc[14:0], 1'b0};
  end

endmodule

// File: rtl/sd_dat_writer.sv
// 4-bit SD DAT single-block writer: start bit, payload, per-lane CRC16,
// end bit, CRC status token capture and busy wait.
// Optional feature macro: SD_DAT_WRITER_STATUS_TIMEOUT_EN (status start-bit timeout).
//
// state          | meaning
// ST_IDLE        | bus released, waiting for start
// ST_START       | driving start bit once the first word is available
// ST_DATA        | one payload nibble per SD clock, stalls on underrun
// ST_CRC         | 16 cycles of per-lane CRC16, MSB first
// ST_END         | end bit (all lanes high), still driven
// ST_TURN        | 2 cycles bus turnaround, released
// ST_STATUS_WAIT | waiting for the card's status start bit on DAT0
// ST_STATUS      | 3 token bits then the ignored end bit
// ST_BUSY        | waiting for DAT0 to go high (card programming)
module sd_dat_writer
  import sd_dat_writer_pkg::*;
#(
  parameter int BLOCK_BYTES = 512
`ifdef SD_DAT_WRITER_STATUS_TIMEOUT_EN
  , parameter int STATUS_TIMEOUT = 64
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [3:0]  sd_dat_out,
  output logic        sd_dat_oe,
  input  logic [3:0]  sd_dat_in,
  output logic        sd_clk_en,
  output logic        busy,
  output logic        done,
  output logic [2:0]  status,
  output logic        timeout
);

  localparam int NIB_LAST = BLOCK_BYTES * 2 - 1;
  localparam int NIB_W    = $clog2(BLOCK_BYTES * 2);
`ifdef SD_DAT_WRITER_STATUS_TIMEOUT_EN
  localparam int CNT_W    = ($clog2(STATUS_TIMEOUT) > 4) ? $clog2(STATUS_TIMEOUT) : 4;
`else
  localparam int CNT_W    = 4;
`endif

  state_t             state;
  logic [15:0]        shift_reg;
  logic [NIB_W-1:0]   nib_cnt;
  logic [CNT_W-1:0]   cnt;
  logic               last_nib;
  logic               word_end;
  logic               stall;
  logic [3:0]         crc_bits;
  logic               unused_dat_in;

  assign last_nib      = (nib_cnt == NIB_W'(NIB_LAST));
  assign word_end      = (nib_cnt[1:0] == 2'd3);
  assign sd_clk_en     = ~stall;
  assign unused_dat_in = ^sd_dat_in[3:1];

  // word request and underrun stall decode from state/counter only
  always_comb begin
    wr_ready = 1'b0;
    if (state == ST_START) wr_ready = 1'b1;
    else if (state == ST_DATA && word_end && !last_nib) wr_ready = 1'b1;
    stall = wr_ready && !wr_valid;
  end

  // DAT drive selection; a stalled Start keeps the bus released
  always_comb begin
    sd_dat_oe  = 1'b0;
    sd_dat_out = 4'hF;
    case (state)
      ST_START: begin
        sd_dat_oe  = ~stall;
        sd_dat_out = stall ? 4'hF : 4'h0;
      end
      ST_DATA: begin
        sd_dat_oe  = 1'b1;
        sd_dat_out = shift_reg[15:12];
      end
      ST_CRC: begin
        sd_dat_oe  = 1'b1;
        sd_dat_out = crc_bits;
      end
      ST_END:  sd_dat_oe = 1'b1;
      default: ;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    sd_crc16_lane u_crc (
      .clk   (clk),
      .rst   (rst),
      .clear (state == ST_IDLE),
      .en    (state == ST_DATA && !stall),
      .shift (state == ST_CRC),
      .din   (shift_reg[12 + i]),
      .dout  (crc_bits[i])
    );
  end

`ifndef SD_DAT_WRITER_STATUS_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  // block sequencing FSM with registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      nib_cnt   <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      status    <= 3'b000;
`ifdef SD_DAT_WRITER_STATUS_TIMEOUT_EN
      timeout   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // done still high means this is the completion cycle: ignore start
          if (start && !done) begin
            state  <= ST_START;
            busy   <= 1'b1;
            status <= 3'b000;
`ifdef SD_DAT_WRITER_STATUS_TIMEOUT_EN
            timeout <= 1'b0;
`endif
          end
        end
        ST_START: begin
          if (wr_valid) begin
            shift_reg <= wr_data;
            nib_cnt   <= '0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!stall) begin
            if (last_nib) begin
              state <= ST_CRC;
              cnt   <= CNT_W'(15);
            end else begin
              nib_cnt   <= nib_cnt + 1'b1;
              shift_reg <= word_end ? wr_data : {shift_reg[11:0], 4'h0};
            end
          end
        end
        ST_CRC: begin
          if (cnt == '0) state <= ST_END;
          else           cnt   <= cnt - 1'b1;
        end
        ST_END: begin
          state <= ST_TURN;
          cnt   <= CNT_W'(1);
        end
        ST_TURN: begin
          if (cnt == '0) begin
            state <= ST_STATUS_WAIT;
`ifdef SD_DAT_WRITER_STATUS_TIMEOUT_EN
            cnt   <= CNT_W'(STATUS_TIMEOUT - 1);
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STATUS_WAIT: begin
          if (!sd_dat_in[0]) begin
            state <= ST_STATUS;
            cnt   <= CNT_W'(3);
          end
`ifdef SD_DAT_WRITER_STATUS_TIMEOUT_EN
          else if (cnt == '0) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            status  <= 3'b000;
          end else begin
            cnt <= cnt - 1'b1;
          end
`endif
        end
        ST_STATUS: begin
          // counts 3..1 carry token bits, 0 is the end bit
          if (cnt != '0) status <= {status[1:0], sd_dat_in[0]};
          if (cnt == '0) state  <= ST_BUSY;
          else           cnt    <= cnt - 1'b1;
        end
        ST_BUSY: begin
          if (sd_dat_in[0]) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_dat_writer.sv
// Directed bench for sd_dat_writer with a 4-byte block.
module tb_sd_dat_writer;
  import sd_dat_writer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  sd_dat_out;
  logic        sd_dat_oe;
  logic [3:0]  sd_dat_in;
  logic        sd_clk_en;
  logic        busy;
  logic        done;
  logic [2:0]  status;
  logic        timeout;

  int compared   = 0;
  int mismatched = 0;

  logic [3:0] nibs [8];

  always #5 clk = ~clk;

  sd_dat_writer #(.BLOCK_BYTES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .sd_dat_out (sd_dat_out),
    .sd_dat_oe  (sd_dat_oe),
    .sd_dat_in  (sd_dat_in),
    .sd_clk_en  (sd_clk_en),
    .busy       (busy),
    .done       (done),
    .status     (status),
    .timeout    (timeout)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic        fb;
    logic [15:0] n;
    fb    = c[15] ^ b;
    n     = {c[14:0], 1'b0};
    n[0]  = fb;
    n[5]  = c[4] ^ fb;
    n[12] = c[11] ^ fb;
    return n;
  endfunction

  task automatic run_block(input int stall_cycles, input bit poke_start, input bit expect_to,
                           input int hold_high, input logic [2:0] tok, input int busy_len);
    logic [15:0] crc_exp [4];
    logic [3:0]  crc_nib;
    int          n;
    for (int i = 0; i < 4; i++) begin
      crc_exp[i] = 16'h0000;
      for (int k = 0; k < 8; k++) crc_exp[i] = crc_step(crc_exp[i], nibs[k][i]);
    end

    sd_dat_in = 4'hF; wr_valid = 1'b0; start = 1'b1;
    settle();
    check("idle_oe", {15'd0, sd_dat_oe}, 16'd0);
    check("idle_busy", {15'd0, busy}, 16'd0);
    tick(); start = 1'b0;
    settle();
    check("start_nodata_clk_en", {15'd0, sd_clk_en}, 16'd0);
    check("start_nodata_oe", {15'd0, sd_dat_oe}, 16'd0);
    check("start_nodata_dat", {12'd0, sd_dat_out}, 16'hF);
    check("start_busy", {15'd0, busy}, 16'd1);
    tick();
    wr_valid = 1'b1; wr_data = 16'h1234;
    settle();
    check("start_bit_dat", {12'd0, sd_dat_out}, 16'h0);
    check("start_bit_oe", {15'd0, sd_dat_oe}, 16'd1);
    check("start_bit_clk_en", {15'd0, sd_clk_en}, 16'd1);
    check("start_ready", {15'd0, wr_ready}, 16'd1);
    tick();
    wr_data = 16'hABCD;

    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        for (int s = 0; s < stall_cycles; s++) begin
          wr_valid = 1'b0;
          settle();
          check("stall_clk_en", {15'd0, sd_clk_en}, 16'd0);
          check("stall_dat_held", {12'd0, sd_dat_out}, {12'd0, nibs[3]});
          check("stall_ready", {15'd0, wr_ready}, 16'd1);
          tick();
        end
        wr_valid = 1'b1;
      end
      if (poke_start && k == 5) start = 1'b1;
      settle();
      check("data_nibble", {12'd0, sd_dat_out}, {12'd0, nibs[k]});
      check("data_clk_en", {15'd0, sd_clk_en}, 16'd1);
      check("data_ready", {15'd0, wr_ready}, {15'd0, (k == 3)});
      tick();
      start = 1'b0;
    end

    for (int k = 0; k < 16; k++) begin
      crc_nib = {crc_exp[3][15-k], crc_exp[2][15-k], crc_exp[1][15-k], crc_exp[0][15-k]};
      settle();
      check("crc_nibble", {12'd0, sd_dat_out}, {12'd0, crc_nib});
      check("crc_oe", {15'd0, sd_dat_oe}, 16'd1);
      tick();
    end

    settle();
    check("end_dat", {12'd0, sd_dat_out}, 16'hF);
    check("end_oe", {15'd0, sd_dat_oe}, 16'd1);
    tick();
    for (int k = 0; k < 2; k++) begin
      settle();
      check("turn_oe", {15'd0, sd_dat_oe}, 16'd0);
      check("turn_busy", {15'd0, busy}, 16'd1);
      tick();
    end

    if (expect_to) begin
      n = 0;
      while (done !== 1'b1 && n < 200) begin
        tick();
        n++;
      end
      check("timeout_cycles", n[15:0], 16'd64);
      check("timeout_flag", {15'd0, timeout}, 16'd1);
      check("timeout_status", {13'd0, status}, 16'd0);
      check("timeout_busy", {15'd0, busy}, 16'd0);
      tick();
      return;
    end

    for (int h = 0; h < hold_high; h++) begin
      settle();
      check("wait_no_done", {15'd0, done}, 16'd0);
      tick();
    end
    sd_dat_in = 4'hE;
    tick();
    for (int b = 2; b >= 0; b--) begin
      sd_dat_in = {3'b111, tok[b]};
      tick();
    end
    sd_dat_in = 4'hF;
    tick();
    for (int b = 0; b < busy_len; b++) begin
      sd_dat_in = 4'hE;
      settle();
      check("card_busy_no_done", {15'd0, done}, 16'd0);
      check("card_busy_busy", {15'd0, busy}, 16'd1);
      tick();
    end
    sd_dat_in = 4'hF;
    settle();
    check("busy_release_no_done", {15'd0, done}, 16'd0);
    tick();
    start = 1'b1;
    settle();
    check("done_pulse", {15'd0, done}, 16'd1);
    check("done_busy_low", {15'd0, busy}, 16'd0);
    check("done_status", {13'd0, status}, {13'd0, tok});
    check("done_timeout", {15'd0, timeout}, 16'd0);
    tick();
    start = 1'b0;
    settle();
    check("done_one_cycle", {15'd0, done}, 16'd0);
    check("start_with_done_ignored", {15'd0, busy}, 16'd0);
    check("status_held", {13'd0, status}, {13'd0, tok});
    tick();
  endtask

  initial begin
    nibs = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD};
    rst = 1'b1; start = 1'b0; wr_valid = 1'b0; wr_data = 16'h0000; sd_dat_in = 4'hF;
    #12;
    check("rst_ready", {15'd0, wr_ready}, 16'd0);
    check("rst_dat", {12'd0, sd_dat_out}, 16'hF);
    check("rst_oe", {15'd0, sd_dat_oe}, 16'd0);
    check("rst_clk_en", {15'd0, sd_clk_en}, 16'd1);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_status", {13'd0, status}, 16'd0);
    check("rst_timeout", {15'd0, timeout}, 16'd0);
    rst = 1'b0;
    tick();

    run_block(0, 1'b1, 1'b0, 2, STATUS_ACCEPTED, 0);
    run_block(3, 1'b0, 1'b0, 0, STATUS_ACCEPTED, 0);
    run_block(0, 1'b0, 1'b0, 0, STATUS_CRC_ERR, 10);
`ifdef SD_DAT_WRITER_STATUS_TIMEOUT_EN
    run_block(0, 1'b0, 1'b1, 0, 3'b000, 0);
`else
    run_block(0, 1'b0, 1'b0, 100, STATUS_WRITE_ERR, 3);
`endif

    start = 1'b1;
    tick(); start = 1'b0;
    wr_valid = 1'b1; wr_data = 16'h1234;
    tick(); tick(); tick();
    settle();
    check("pre_rst_oe", {15'd0, sd_dat_oe}, 16'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_oe", {15'd0, sd_dat_oe}, 16'd0);
    check("mid_rst_dat", {12'd0, sd_dat_out}, 16'hF);
    check("mid_rst_busy", {15'd0, busy}, 16'd0);
    check("mid_rst_ready", {15'd0, wr_ready}, 16'd0);
    tick(); tick();
    check("mid_rst_no_done", {15'd0, done}, 16'd0);
    rst = 1'b0;
    tick();
    check("post_rst_no_done", {15'd0, done}, 16'd0);

    run_block(0, 1'b0, 1'b0, 1, STATUS_WRITE_ERR, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sd_dat_writer.md
# sd_dat_writer

Drives the 4-bit SD DAT bus for a single-block write (CMD24/CMD25 data phase), the write-direction counterpart of the SD readout path that streams card data to the STM. It accepts 16-bit words from an upstream buffer fed by STM SPI, serializes them onto DAT[3:0] with start bit, per-lane CRC16 and end bit, then receives the card's CRC status token and waits out busy. It sits between the STM-side write FIFO and the SD pad drivers, in the SD clock domain.

## Interface
- BLOCK_BYTES, 512, payload bytes per block; even, ≥2
- STATUS_TIMEOUT, 64, max cycles from turnaround end to status start bit
- clk  in  1  SD-domain clock; SD card clock toggles when sd_clk_en=1
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins one block; ignored unless Idle
- wr_data  in  16  payload word; [15:12] transmitted first
- wr_valid  in  1  wr_data valid
- wr_ready  out  1  word accepted on wr_valid&&wr_ready
- sd_dat_out  out  4  DAT drive value
- sd_dat_oe  out  1  DAT output enable
- sd_dat_in  in  4  sampled DAT pins (DAT0 used for status/busy)
- sd_clk_en  out  1  0 stalls the SD clock (data underrun)
- busy  out  1  block in progress (not Idle)
- done  out  1  one-cycle pulse at block completion
- status  out  3  CRC status token bits, valid with done, held until next start
- timeout  out  1  status start bit not seen; valid with done

## Operation
- States: Idle, Start, Data, Crc, End, Turn, StatusWait, Status, Busy.
- Idle: oe=0, dat_out=4'hF. start → Start.
- Start: wr_ready=1. On handshake: load word into 16-bit shift register, drive dat_out=0, oe=1, sd_clk_en=1, → Data. No word: sd_clk_en=0, dat_out=4'hF, oe=0, stay.
- Data: one nibble per cycle from shift register MSB nibble, shift left 4. Nibble counter 0..BLOCK_BYTES*2-1. On phase==3 of a non-final word, wr_ready=1; handshake reloads shift register next cycle; no word → sd_clk_en=0, dat_out/counter/CRC held, retry. Last nibble → Crc.
- Crc: 16 cycles; lane i drives its CRC16 (x^16+x^12+x^5+1, init 0) MSB first. → End.
- End: dat_out=4'hF, oe=1, one cycle. → Turn.
- Turn: oe=0, 2 cycles. → StatusWait.
- StatusWait: wait sd_dat_in[0]==0 (start bit) → Status.
- Status: capture 3 bits of DAT0 MSB first into status, 4th cycle (end bit) ignored. → Busy.
- Busy: wait sd_dat_in[0]==1 → Idle with done=1.
- Status codes: 3'b010 accepted, 3'b101 CRC error, 3'b110 write error; other values reported unchanged.
- Each lane CRC updated only on cycles where a data nibble is actually driven (sd_clk_en=1 in Data).

## Timing
- Reset values: wr_ready=0, sd_dat_out=4'hF, sd_dat_oe=0, sd_clk_en=1, busy=0, done=0, status=3'b000, timeout=0; state Idle, counters 0.
- Reset mid-block: immediate abandonment, bus released; no done pulse.
- No-stall block: start at cycle 0 (Idle) → Start cycle 1 (start bit) → data cycles 2..BLOCK_BYTES*2+1 → CRC 16 cycles → End 1 → Turn 2 → status/busy card-dependent.
- wr_ready combinational from state/counter only; never depends on wr_valid.
- start during busy=1: ignored, no queueing. start coincident with done: ignored.
- sd_clk_en=0 only in Start or Data; all other states 1.
- done and busy-fall occur same cycle.

## Configuration
- SD_DAT_WRITER_STATUS_TIMEOUT_EN defined: StatusWait counts cycles; at STATUS_TIMEOUT → Idle, done=1, timeout=1, status=3'b000.
- Undefined: StatusWait waits indefinitely; timeout tied 0, no counter synthesized.

## Structure
- Package sd_dat_writer_pkg: state enum, status code constants (ACCEPTED, CRC_ERR, WRITE_ERR), CRC16 polynomial constant.
- Sub-module sd_crc16_lane: serial 1-bit CRC16 with en/clear/shift-out, instantiated once per DAT lane.

## Test plan
- BLOCK_BYTES=4, words 16'h1234,16'hABCD, always valid → DAT sequence 0,1,2,3,4,A,B,C,D, lane CRCs match software model, then F; card status 010 → done, status=3'b010.
- Same block, wr_valid low 3 cycles at word 2 → sd_clk_en=0 for 3 cycles, DAT/CRC identical to no-stall case.
- Card returns 101 then busy 10 cycles → done 10 cycles after status end, status=3'b101, busy falls with done.
- Macro defined, DAT0 held high after Turn → done after STATUS_TIMEOUT=64 cycles, timeout=1.
- start pulse during Data → ignored; rst asserted mid-Data → oe=0, dat_out=F, busy=0 same cycle, no done.
